// File: rtl/sd_io_arbiter_if.sv
// Request/acknowledge bundle between the sd_card drive requesters and the HPS sector interface.
// The master side is the arbiter; the slave side is the drives plus the HPS responder.
interface sd_io_arbiter_if #(
  parameter int NDRV = 2,
  parameter int WIDE = 0
);
  localparam int DW = (WIDE != 0) ? 15 : 7;

  logic [NDRV-1:0]        drv_en;
  logic [32*NDRV-1:0]     drv_lba;
  logic [NDRV-1:0]        drv_rd;
  logic [NDRV-1:0]        drv_wr;
  logic [NDRV-1:0]        drv_ack;
  logic [(DW+1)*NDRV-1:0] drv_buff_din;
  logic [31:0]            sd_lba;
  logic                   sd_rd;
  logic                   sd_wr;
  logic [1:0]             sd_drv;
  logic                   sd_ack;
  logic [DW:0]            sd_buff_din;
  logic                   to_err;

  modport master (
    input  drv_en, drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack,
    output drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, sd_buff_din, to_err
  );

  modport slave (
    output drv_en, drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack,
    input  drv_ack, sd_lba, sd_rd, sd_wr, sd_drv, sd_buff_din, to_err
  );
endinterface

// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter sharing one HPS sector request channel between NDRV sd_card drives,
// with a request timeout and a retire guard against double grants from slow-dropping levels.
module sd_io_arbiter #(
  parameter int NDRV = 2,
  parameter int WIDE = 0,
  parameter int TO_W = 24
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  sd_io_arbiter_if.master bus
);
  localparam int              DW       = (WIDE != 0) ? 15 : 7;
  localparam logic [1:0]      LAST_RST = 2'(NDRV - 1);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      sel_r, sel_nxt_s;
  logic [1:0]      last_grant_r, last_grant_nxt_s;
  logic [NDRV-1:0] retire_r, retire_nxt_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
  logic [31:0]     sd_lba_r, sd_lba_nxt_s;
  logic [1:0]      sd_drv_r, sd_drv_nxt_s;
  logic            sd_rd_r, sd_rd_nxt_s;
  logic            sd_wr_r, sd_wr_nxt_s;
  logic            to_err_r, to_err_nxt_s;

  logic [NDRV-1:0] pending_s;
  logic            found_s;
  logic [1:0]      grant_s;
  logic [31:0]     grant_lba_s;
  logic            grant_rd_s;
  logic            grant_wr_s;
  logic            sel_en_s;
  logic [DW:0]     sel_buff_s;
  logic [NDRV-1:0] drv_ack_s;

  // Requests still waiting for service; a retired drive stays masked until its level drops.
  always_comb begin
    pending_s = bus.drv_en & (bus.drv_rd | bus.drv_wr) & ~retire_r;
  end

  // Round-robin pick: first pending drive scanning from last_grant+1, wrapping modulo NDRV.
  always_comb begin
    found_s = 1'b0;
    grant_s = 2'd0;
    for (int k = 1; k <= NDRV; k++) begin
      for (int j = 0; j < NDRV; j++) begin
        if (!found_s && pending_s[j] && (j == ((int'(last_grant_r) + k) % NDRV))) begin
          found_s = 1'b1;
          grant_s = j[1:0];
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // AND-OR muxes for the drive being granted and the drive currently selected.
  always_comb begin
    grant_lba_s = 32'd0;
    grant_rd_s  = 1'b0;
    grant_wr_s  = 1'b0;
    sel_en_s    = 1'b0;
    sel_buff_s  = {(DW+1){1'b0}};
    for (int i = 0; i < NDRV; i++) begin
      grant_lba_s = grant_lba_s | ({32{grant_s == i[1:0]}} & bus.drv_lba[32*i +: 32]);
      grant_rd_s  = grant_rd_s  | ((grant_s == i[1:0]) & bus.drv_rd[i]);
      grant_wr_s  = grant_wr_s  | ((grant_s == i[1:0]) & bus.drv_wr[i]);
      sel_en_s    = sel_en_s    | ((sel_r == i[1:0]) & bus.drv_en[i]);
      sel_buff_s  = sel_buff_s  | ({(DW+1){sel_r == i[1:0]}} & bus.drv_buff_din[(DW+1)*i +: DW+1]);
    end
  end

  // Acknowledge is passed straight through to the selected drive while its request is live.
  always_comb begin
    drv_ack_s = {NDRV{1'b0}};
    for (int i = 0; i < NDRV; i++) begin
      drv_ack_s[i] = ((state_r == ST_REQ) || (state_r == ST_XFER)) && (sel_r == i[1:0]) && bus.sd_ack;
    end
  end

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    state_nxt_s      = state_r;
    sel_nxt_s        = sel_r;
    last_grant_nxt_s = last_grant_r;
    to_cnt_nxt_s     = to_cnt_r;
    sd_lba_nxt_s     = sd_lba_r;
    sd_drv_nxt_s     = sd_drv_r;
    sd_rd_nxt_s      = sd_rd_r;
    sd_wr_nxt_s      = sd_wr_r;
    to_err_nxt_s     = 1'b0;
    retire_nxt_s     = retire_r & (bus.drv_rd | bus.drv_wr);
    case (state_r)
      ST_IDLE: begin
        to_cnt_nxt_s = {TO_W{1'b0}};
        if (found_s) begin
          sel_nxt_s    = grant_s;
          sd_drv_nxt_s = grant_s;
          sd_lba_nxt_s = grant_lba_s;
          sd_rd_nxt_s  = grant_rd_s;
          sd_wr_nxt_s  = grant_wr_s & ~grant_rd_s;
          state_nxt_s  = ST_REQ;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.sd_ack) begin
          sd_rd_nxt_s = 1'b0;
          sd_wr_nxt_s = 1'b0;
          state_nxt_s = ST_XFER;
        end else if (!sel_en_s || (&to_cnt_r)) begin
          // Unmount and timeout both abandon the request without retiring it.
          sd_rd_nxt_s      = 1'b0;
          sd_wr_nxt_s      = 1'b0;
          to_err_nxt_s     = sel_en_s;
          last_grant_nxt_s = sel_r;
          state_nxt_s      = ST_IDLE;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TO_ONE;
        end
      end
      ST_XFER: begin
        if (!bus.sd_ack) begin
          for (int i = 0; i < NDRV; i++) begin
            retire_nxt_s[i] = retire_nxt_s[i] | (sel_r == i[1:0]);
          end
          last_grant_nxt_s = sel_r;
          state_nxt_s      = ST_DONE;
        end else begin
          state_nxt_s      = ST_XFER;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        sd_rd_nxt_s = 1'b0;
        sd_wr_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered HPS-side outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      sel_r        <= 2'd0;
      last_grant_r <= LAST_RST;
      retire_r     <= {NDRV{1'b0}};
      to_cnt_r     <= {TO_W{1'b0}};
      sd_lba_r     <= 32'd0;
      sd_drv_r     <= 2'd0;
      sd_rd_r      <= 1'b0;
      sd_wr_r      <= 1'b0;
      to_err_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sel_r        <= sel_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      retire_r     <= retire_nxt_s;
      to_cnt_r     <= to_cnt_nxt_s;
      sd_lba_r     <= sd_lba_nxt_s;
      sd_drv_r     <= sd_drv_nxt_s;
      sd_rd_r      <= sd_rd_nxt_s;
      sd_wr_r      <= sd_wr_nxt_s;
      to_err_r     <= to_err_nxt_s;
    end
  end

  assign bus.sd_lba      = sd_lba_r;
  assign bus.sd_drv      = sd_drv_r;
  assign bus.sd_rd       = sd_rd_r;
  assign bus.sd_wr       = sd_wr_r;
  assign bus.to_err      = to_err_r;
  assign bus.drv_ack     = drv_ack_s;
  assign bus.sd_buff_din = sel_buff_s;
endmodule

// File: tb/tb_sd_io_arbiter.sv
// Self-checking bench for sd_io_arbiter: directed scenarios followed by randomized request
// rounds scored against a transaction-level round-robin model.
module tb_sd_io_arbiter;
  localparam int NDRV = 2;
  localparam int WIDE = 0;
  localparam int TO_W = 4;
  localparam int DW   = 7;

  logic clk_sys;
  logic reset_n;

  sd_io_arbiter_if #(.NDRV(NDRV), .WIDE(WIDE)) bus ();

  sd_io_arbiter #(.NDRV(NDRV), .WIDE(WIDE), .TO_W(TO_W)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int          n_checks;
  int          n_pass;
  int          drop_cnt    [NDRV];
  bit          outstanding [NDRV];
  bit          req_rd      [NDRV];
  bit          req_wr      [NDRV];
  logic [31:0] req_lba     [NDRV];
  logic [DW:0] buff_v      [NDRV];
  int          model_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock; samples land 1 ns after the rising edge. Requesters drop late by drop_cnt cycles.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    for (int i = 0; i < NDRV; i++) begin
      if (drop_cnt[i] > 0) begin
        drop_cnt[i]--;
        if (drop_cnt[i] == 0) begin
          bus.drv_rd[i] = 1'b0;
          bus.drv_wr[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_lba(input int i, input logic [31:0] v);
    req_lba[i] = v;
    bus.drv_lba[32*i +: 32] = v;
  endtask

  task automatic load_buff();
    for (int i = 0; i < NDRV; i++) bus.drv_buff_din[(DW+1)*i +: DW+1] = buff_v[i];
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.sd_ack  = 1'b0;
    bus.drv_rd  = 2'b00;
    bus.drv_wr  = 2'b00;
    for (int i = 0; i < NDRV; i++) begin
      drop_cnt[i]    = 0;
      outstanding[i] = 1'b0;
    end
    tick();
    tick();
    reset_n    = 1'b1;
    model_last = NDRV - 1;
    tick();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (bus.sd_rd || bus.sd_wr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("grant_wait", 32'(ok), 32'd1);
  endtask

  // HPS responder: ack after ack_dly cycles, hold it hold+1 cycles, then release.
  task automatic serve(input int d, input int ack_dly, input int hold);
    for (int t = 0; t < ack_dly; t++) tick();
    bus.sd_ack = 1'b1;
    #1;
    check_eq("drv_ack_req", 32'(bus.drv_ack), 32'(1 << d));
    check_eq("buff_mux", 32'(bus.sd_buff_din), 32'(buff_v[d]));
    tick();
    check_eq("ack_clears_rdwr", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
    for (int t = 0; t < hold; t++) tick();
    check_eq("drv_ack_xfer", 32'(bus.drv_ack), 32'(1 << d));
    bus.sd_ack = 1'b0;
    #1;
    check_eq("drv_ack_release", 32'(bus.drv_ack), 32'd0);
    tick();
  endtask

  // No ack: counter runs 0..15 in REQ (16 cycles), then abort with a single to_err pulse.
  task automatic expire();
    for (int t = 0; t < 15; t++) tick();
    check_eq("to_hold", 32'(bus.sd_rd | bus.sd_wr), 32'd1);
    check_eq("to_err_early", 32'(bus.to_err), 32'd0);
    tick();
    check_eq("to_rdwr_clr", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
    check_eq("to_err_pulse", 32'(bus.to_err), 32'd1);
    tick();
    check_eq("to_err_once", 32'(bus.to_err), 32'd0);
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NDRV; k++) begin
      if (outstanding[(model_last + k) % NDRV]) return (model_last + k) % NDRV;
    end
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int g;
    int e;
    int mask;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b1;
    bus.drv_en = 2'b00;
    bus.drv_lba = 64'd0;
    bus.drv_rd = 2'b00;
    bus.drv_wr = 2'b00;
    bus.drv_buff_din = 16'd0;
    bus.sd_ack = 1'b0;
    buff_v[0] = 8'h5A;
    buff_v[1] = 8'hC3;
    load_buff();
    for (int i = 0; i < NDRV; i++) drop_cnt[i] = 0;
    #2;
    reset_n = 1'b0;
    tick();
    tick();
    check_eq("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
    check_eq("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
    check_eq("rst_sd_lba", bus.sd_lba, 32'd0);
    check_eq("rst_sd_drv", 32'(bus.sd_drv), 32'd0);
    check_eq("rst_to_err", 32'(bus.to_err), 32'd0);
    check_eq("rst_drv_ack", 32'(bus.drv_ack), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single read on drive 0.
    bus.drv_en = 2'b11;
    set_lba(0, 32'h0000_1234);
    bus.drv_rd[0] = 1'b1;
    tick();
    check_eq("single_rd", 32'(bus.sd_rd), 32'd1);
    check_eq("single_wr", 32'(bus.sd_wr), 32'd0);
    check_eq("single_lba", bus.sd_lba, 32'h0000_1234);
    check_eq("single_drv", 32'(bus.sd_drv), 32'd0);
    serve(0, 2, 1);

    // Retire guard: level held 20 more cycles must not re-grant.
    g = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus.sd_rd || bus.sd_wr) g++;
    end
    check_eq("retire_hold", 32'(g), 32'd0);
    bus.drv_rd[0] = 1'b0;
    tick();
    bus.drv_rd[0] = 1'b1;
    tick();
    check_eq("retire_regrant_rd", 32'(bus.sd_rd), 32'd1);
    check_eq("retire_regrant_drv", 32'(bus.sd_drv), 32'd0);
    serve(0, 0, 0);
    bus.drv_rd[0] = 1'b0;
    tick();

    // Contention after reset: order 0,1,0,1.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_lba(0, 32'h0000_0100 + 32'(r));
      set_lba(1, 32'h0000_0200 + 32'(r));
      bus.drv_rd[0] = 1'b1;
      bus.drv_wr[1] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        wait_grant(ok);
        check_eq("cont_drv", 32'(bus.sd_drv), 32'(s));
        check_eq("cont_rw", 32'({bus.sd_rd, bus.sd_wr}), (s == 0) ? 32'd2 : 32'd1);
        check_eq("cont_lba", bus.sd_lba, req_lba[s]);
        serve(s, 1, 0);
      end
      bus.drv_rd[0] = 1'b0;
      bus.drv_wr[1] = 1'b0;
      tick();
    end

    // Timeout on drive 0; drive 1 is next, then drive 0 again (not retired).
    bus.drv_rd[0] = 1'b1;
    bus.drv_wr[1] = 1'b1;
    tick();
    check_eq("to_first_drv", 32'(bus.sd_drv), 32'd0);
    expire();
    check_eq("to_next_drv", 32'(bus.sd_drv), 32'd1);
    check_eq("to_next_wr", 32'(bus.sd_wr), 32'd1);
    serve(1, 0, 0);
    wait_grant(ok);
    check_eq("to_regrant_drv", 32'(bus.sd_drv), 32'd0);
    serve(0, 0, 0);
    bus.drv_rd[0] = 1'b0;
    bus.drv_wr[1] = 1'b0;
    tick();

    // Disabled drive is ignored until enabled.
    bus.drv_en = 2'b01;
    bus.drv_wr[1] = 1'b1;
    g = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (bus.sd_rd || bus.sd_wr) g++;
    end
    check_eq("dis_no_grant", 32'(g), 32'd0);
    bus.drv_en = 2'b11;
    tick();
    check_eq("dis_grant_wr", 32'(bus.sd_wr), 32'd1);
    check_eq("dis_grant_drv", 32'(bus.sd_drv), 32'd1);
    serve(1, 0, 0);
    bus.drv_wr[1] = 1'b0;
    tick();

    // Unmount during REQ aborts without to_err.
    bus.drv_rd[0] = 1'b1;
    bus.drv_wr[1] = 1'b1;
    tick();
    check_eq("abort_grant_drv", 32'(bus.sd_drv), 32'd0);
    bus.drv_en[0] = 1'b0;
    tick();
    check_eq("abort_rdwr", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
    check_eq("abort_no_err", 32'(bus.to_err), 32'd0);
    tick();
    check_eq("abort_next_drv", 32'(bus.sd_drv), 32'd1);
    serve(1, 0, 0);
    bus.drv_en[0] = 1'b1;
    wait_grant(ok);
    check_eq("abort_regrant_drv", 32'(bus.sd_drv), 32'd0);
    serve(0, 0, 0);
    bus.drv_rd[0] = 1'b0;
    bus.drv_wr[1] = 1'b0;
    tick();

    // Reset during XFER drops everything, drive 0 is first afterwards.
    set_lba(1, 32'hDEAD_0001);
    bus.drv_rd[1] = 1'b1;
    tick();
    check_eq("mrst_grant_drv", 32'(bus.sd_drv), 32'd1);
    bus.sd_ack = 1'b1;
    tick();
    check_eq("mrst_xfer_ack", 32'(bus.drv_ack), 32'd2);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_rdwr", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
    check_eq("mrst_drv_ack", 32'(bus.drv_ack), 32'd0);
    check_eq("mrst_lba", bus.sd_lba, 32'd0);
    bus.sd_ack = 1'b0;
    bus.drv_rd[0] = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("mrst_first_drv", 32'(bus.sd_drv), 32'd0);
    serve(0, 0, 0);
    wait_grant(ok);
    check_eq("mrst_no_retire", 32'(bus.sd_drv), 32'd1);
    serve(1, 0, 0);
    bus.drv_rd = 2'b00;
    tick();

    // Randomized rounds against the round-robin model.
    do_reset();
    for (int round = 0; round < 40; round++) begin
      mask = $urandom_range(1, 3);
      for (int i = 0; i < NDRV; i++) begin
        buff_v[i] = 8'($urandom);
        if (mask[i]) begin
          outstanding[i] = 1'b1;
          req_rd[i] = 1'($urandom_range(0, 1));
          req_wr[i] = req_rd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          set_lba(i, $urandom);
          bus.drv_rd[i] = req_rd[i];
          bus.drv_wr[i] = req_wr[i];
        end
      end
      load_buff();
      while (rr_pick() >= 0) begin
        wait_grant(ok);
        if (!ok) break;
        e = rr_pick();
        check_eq("rnd_drv", 32'(bus.sd_drv), 32'(e));
        check_eq("rnd_lba", bus.sd_lba, req_lba[e]);
        check_eq("rnd_rw", 32'({bus.sd_rd, bus.sd_wr}), 32'({req_rd[e], req_wr[e] & ~req_rd[e]}));
        model_last = e;
        if ($urandom_range(0, 5) == 0) begin
          expire();
        end else begin
          serve(e, $urandom_range(0, 8), $urandom_range(0, 3));
          outstanding[e] = 1'b0;
          drop_cnt[e] = $urandom_range(1, 6);
        end
      end
      for (int t = 0; t < 8; t++) tick();
      check_eq("rnd_idle", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
